// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Exhaustive stimulus/checker for an N_IN-input, 1-output combinational block.
//   On start it walks vec_out through 0 .. 2^N_IN-1. Each vector is held for SETTLE
//   cycles in WAIT. In the following CHECK cycle dut_f is judged against
//   EXP_TABLE[vec_out]. The block keeps a mismatch count and the first failing vector,
//   and raises done/pass when the sweep ends.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset, priority over start
//   start          begin a sweep; only honoured in IDLE or DONE
//   vec_out        vector driven to the DUT (MSB = first DUT input)
//   dut_f          DUT output
//   busy           sweep in progress (WAIT or CHECK)
//   done           sweep finished; held until start or rst
//   pass           done with zero mismatches
//   log_valid      this cycle judges vec_out/dut_f (combinational)
//   mismatch       log_valid and dut_f differs from golden (combinational)
//   err_count      number of mismatching vectors this sweep
//   first_err_vec  first mismatching vector, valid with first_err_vld
//   first_err_vld  at least one mismatch this sweep
module truth_table_sweeper #(
  parameter int                   N_IN      = 3,
  parameter logic [(1<<N_IN)-1:0] EXP_TABLE = 8'b10010110,
  parameter int                   SETTLE    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            dut_f,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            log_valid,
  output logic            mismatch,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err_vec,
  output logic            first_err_vld
);

  // Wait counter only needs to reach SETTLE-1; keep at least one bit.
  localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = 1;
  localparam logic [N_IN-1:0]   VEC_ONE   = 1;
  localparam logic [N_IN-1:0]   VEC_LAST  = '1;
  localparam logic [N_IN:0]     ERR_ONE   = 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [N_IN:0]     err_q, err_d;
  logic [N_IN-1:0]   fvec_q, fvec_d;
  logic              fvld_q, fvld_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  // Judgement is combinational against the sample currently on the wires.
  assign log_valid = (state_q == S_CHECK);
  assign mismatch  = log_valid && (dut_f != EXP_TABLE[vec_q]);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    wait_d  = wait_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    fvld_d  = fvld_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE keeps its results until a new sweep is requested.
        if (start) begin
          vec_d   = '0;
          wait_d  = '0;
          err_d   = '0;
          fvec_d  = '0;
          fvld_d  = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        wait_d = wait_q + WAIT_ONE;
        if (wait_q == WAIT_LAST) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (mismatch) begin
          // Count cannot overflow: at most 2^N_IN mismatches fit in N_IN+1 bits.
          err_d = err_q + ERR_ONE;
          if (!fvld_q) begin
            fvec_d = vec_q;
            fvld_d = 1'b1;
          end
        end
        if (vec_q == VEC_LAST) begin
          // Last vector stays on vec_out; no wrap back to zero.
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + VEC_ONE;
          wait_d  = '0;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status flags are registered copies of the next-state decode.
    busy_d = (state_d == S_WAIT) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      wait_q  <= '0;
      err_q   <= '0;
      fvec_q  <= '0;
      fvld_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      fvld_q  <= fvld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign vec_out       = vec_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_vec = fvec_q;
  assign first_err_vld = fvld_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

  localparam logic [7:0]  EXP3 = 8'b10010110;
  localparam logic [15:0] EXP4 = 16'h6996;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 3-input instance: default parameters
  logic       start3 = 1'b0;
  logic [2:0] vec3;
  logic       f3, busy3, done3, pass3, lv3, mm3, fvld3;
  logic [3:0] err3;
  logic [2:0] fev3;
  logic [7:0] tab3 = 8'h96;
  assign f3 = tab3[vec3];

  // 4-input instance with longer settle time
  logic       start4 = 1'b0;
  logic [3:0] vec4;
  logic       f4, busy4, done4, pass4, lv4, mm4, fvld4;
  logic [4:0] err4;
  logic [3:0] fev4;
  logic [15:0] tab4 = 16'h6996;
  assign f4 = tab4[vec4];

  truth_table_sweeper u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .vec_out(vec3), .dut_f(f3),
    .busy(busy3), .done(done3), .pass(pass3), .log_valid(lv3), .mismatch(mm3),
    .err_count(err3), .first_err_vec(fev3), .first_err_vld(fvld3)
  );

  truth_table_sweeper #(.N_IN(4), .EXP_TABLE(EXP4), .SETTLE(3)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .vec_out(vec4), .dut_f(f4),
    .busy(busy4), .done(done4), .pass(pass4), .log_valid(lv4), .mismatch(mm4),
    .err_count(err4), .first_err_vec(fev4), .first_err_vld(fvld4)
  );

  int checks = 0;
  int errors = 0;

  // Sweep log for the 3-input instance
  int log_vec[$];
  int log_mm[$];
  int log_n[$];
  int sweep_cycles;
  logic post_busy, post_done;
  int   post_err;
  logic post_fvld;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: expected mismatch count and first failing index (-1 when none).
  function automatic void model(input logic [15:0] tab, input logic [15:0] exp_t,
                                input int nvec, output int e_err, output int e_first);
    e_err = 0;
    e_first = -1;
    for (int k = 0; k < nvec; k++)
      if (tab[k] != exp_t[k]) begin
        e_err++;
        if (e_first < 0) e_first = k;
      end
  endfunction

  // Start a sweep on the 3-input instance and log every CHECK cycle until done.
  // pulse_at >= 0 raises start again for one cycle at that cycle index.
  task automatic run_sweep3(input int pulse_at);
    int n;
    log_vec.delete(); log_mm.delete(); log_n.delete();
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    post_busy = busy3; post_done = done3; post_err = int'(err3); post_fvld = fvld3;
    n = 0;
    while (!done3 && n < 200) begin
      if (lv3) begin
        log_vec.push_back(int'(vec3));
        log_mm.push_back(int'(mm3));
        log_n.push_back(n);
      end
      start3 = (n == pulse_at);
      step();
      n++;
    end
    start3 = 1'b0;
    sweep_cycles = n;
  endtask

  // Compares a finished 3-input sweep with the model for the current tab3.
  task automatic check_sweep3(input string tag);
    int e_err, e_first, bad;
    model({8'h00, tab3}, {8'h00, EXP3}, 8, e_err, e_first);
    checks++;
    if (sweep_cycles !== 16) begin
      errors++; $display("FAIL %s cycles: got %0d expected 16", tag, sweep_cycles);
    end
    checks++;
    if (err3 !== 4'(e_err)) begin
      errors++; $display("FAIL %s err_count: got %0d expected %0d", tag, err3, e_err);
    end
    checks++;
    if (pass3 !== (e_err == 0) || done3 !== 1'b1 || busy3 !== 1'b0) begin
      errors++; $display("FAIL %s pass/done/busy: got %b%b%b expected %b10", tag,
                         pass3, done3, busy3, (e_err == 0));
    end
    checks++;
    if (fvld3 !== (e_first >= 0) || (e_first >= 0 && fev3 !== 3'(e_first))) begin
      errors++; $display("FAIL %s first_err: got vld=%b vec=%0d expected vld=%b vec=%0d",
                         tag, fvld3, fev3, (e_first >= 0), e_first);
    end
    checks++;
    if (log_vec.size() !== 8) begin
      errors++; $display("FAIL %s log_valid count: got %0d expected 8", tag, log_vec.size());
    end else begin
      bad = 0;
      for (int k = 0; k < 8; k++)
        if (log_vec[k] != k || log_n[k] != 2*k+1 || log_mm[k] != int'(tab3[k] != EXP3[k]))
          bad++;
      if (bad != 0) begin
        errors++; $display("FAIL %s log entries: got %0d bad entries expected 0", tag, bad);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++;
    if ({busy3, done3, pass3, lv3, mm3, err3, vec3, fev3, fvld3} !== '0) begin
      errors++; $display("FAIL reset3: got %b expected 0",
                         {busy3, done3, pass3, lv3, mm3, err3, vec3, fev3, fvld3});
    end
    checks++;
    if ({busy4, done4, pass4, lv4, mm4, err4, vec4, fev4, fvld4} !== '0) begin
      errors++; $display("FAIL reset4: got %b expected 0",
                         {busy4, done4, pass4, lv4, mm4, err4, vec4, fev4, fvld4});
    end
  endtask

  task automatic test_parity();
    tab3 = 8'h96;
    run_sweep3(-1);
    check_sweep3("parity");
  endtask

  task automatic test_tied0();
    tab3 = 8'h00;
    run_sweep3(-1);
    check_sweep3("tied0");
  endtask

  task automatic test_restart_ignored();
    tab3 = 8'h96;
    run_sweep3(5);
    check_sweep3("restart");
  endtask

  task automatic test_reset_mid();
    int n;
    tab3 = 8'h00;
    start3 = 1'b1; step(); start3 = 1'b0;
    n = 0;
    while (vec3 !== 3'd5 && n < 40) begin step(); n++; end
    checks++;
    if (vec3 !== 3'd5 || err3 === 4'd0) begin
      errors++; $display("FAIL reset_mid reach: got vec=%0d err=%0d expected vec=5 err>0",
                         vec3, err3);
    end
    rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if ({busy3, vec3, err3, done3, lv3, fvld3} !== '0) begin
      errors++; $display("FAIL reset_mid clear: got %b expected 0",
                         {busy3, vec3, err3, done3, lv3, fvld3});
    end
    tab3 = 8'h96;
    run_sweep3(-1);
    check_sweep3("after_reset");
  endtask

  task automatic test_rerun();
    tab3 = 8'h00;
    run_sweep3(-1);
    checks++;
    if (err3 !== 4'd4) begin
      errors++; $display("FAIL rerun setup err: got %0d expected 4", err3);
    end
    tab3 = 8'h96;
    run_sweep3(-1);
    checks++;
    if (post_err !== 0 || post_fvld !== 1'b0 || post_done !== 1'b0 || post_busy !== 1'b1) begin
      errors++; $display("FAIL rerun clear: got err=%0d vld=%b done=%b busy=%b expected 0 0 0 1",
                         post_err, post_fvld, post_done, post_busy);
    end
    check_sweep3("rerun");
  endtask

  task automatic test_random();
    int gap;
    for (int it = 0; it < 6; it++) begin
      tab3 = 8'($urandom);
      run_sweep3(int'($urandom_range(0, 14)));
      check_sweep3("random");
      // Results must hold in DONE while start stays low.
      gap = int'($urandom_range(1, 6));
      for (int g = 0; g < gap; g++) step();
      checks++;
      if (done3 !== 1'b1 || busy3 !== 1'b0 || vec3 !== 3'd7) begin
        errors++; $display("FAIL random hold: got done=%b busy=%b vec=%0d expected 1 0 7",
                           done3, busy3, vec3);
      end
    end
  endtask

  task automatic sweep4(input string tag);
    int n, e_err, e_first, bad, cnt;
    model(tab4, EXP4, 16, e_err, e_first);
    start4 = 1'b1; step(); start4 = 1'b0;
    n = 0; bad = 0; cnt = 0;
    while (!done4 && n < 400) begin
      if (lv4) begin
        if (int'(vec4) != cnt || n != 4*cnt + 3 || mm4 !== (tab4[cnt] != EXP4[cnt])) bad++;
        cnt++;
      end
      step(); n++;
    end
    checks++;
    if (n !== 64) begin
      errors++; $display("FAIL %s cycles: got %0d expected 64", tag, n);
    end
    checks++;
    if (cnt !== 16 || bad !== 0) begin
      errors++; $display("FAIL %s log: got %0d entries %0d bad expected 16 entries 0 bad",
                         tag, cnt, bad);
    end
    checks++;
    if (err4 !== 5'(e_err) || pass4 !== (e_err == 0)) begin
      errors++; $display("FAIL %s result: got err=%0d pass=%b expected err=%0d pass=%b",
                         tag, err4, pass4, e_err, (e_err == 0));
    end
    checks++;
    if (fvld4 !== (e_first >= 0) || (e_first >= 0 && fev4 !== 4'(e_first))) begin
      errors++; $display("FAIL %s first_err: got vld=%b vec=%0d expected vld=%b vec=%0d",
                         tag, fvld4, fev4, (e_first >= 0), e_first);
    end
  endtask

  task automatic test_n4();
    tab4 = 16'h6996;
    sweep4("n4_parity");
    tab4 = 16'($urandom) | 16'h0100;
    tab4[0] = 1'b0;
    sweep4("n4_random");
  endtask

  initial begin
    test_reset();
    test_parity();
    test_tied0();
    test_restart_ignored();
    test_reset_mid();
    test_rerun();
    test_random();
    test_n4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
